// File: rtl/cpu_prog_loader.sv
// Framed nibble-stream loader for the 4-bit CPU's program memory. It holds the CPU until a complete image has been written.
// Optional checksum check: define CPU_PROG_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN   | expecting word count minus 1
// BASE  | expecting first write address
// DATA  | accepting data nibbles; each one is written on the following cycle
// CHK   | expecting checksum nibble (checksum build only)
// DONE  | image loaded, CPU released once the last write has issued
// ERR   | checksum mismatch, CPU stays held (checksum build only)
module cpu_prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_BASE = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK  = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
`endif
  logic              ready;
  logic              xfer;

`ifdef CPU_PROG_LOADER_CHECKSUM_EN
  assign ready = (state_q == ST_LEN) || (state_q == ST_BASE) ||
                 (state_q == ST_DATA) || (state_q == ST_CHK);
`else
  assign ready = (state_q == ST_LEN) || (state_q == ST_BASE) || (state_q == ST_DATA);
`endif
  assign xfer = in_valid & ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_LEN: begin
        if (xfer) begin
          len_d   = in_data[ADDR_W-1:0];
          state_d = ST_BASE;
        end
      end
      ST_BASE: begin
        if (xfer) begin
          base_d  = in_data[ADDR_W-1:0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = base_q + cnt_q;
          wdata_d = in_data;
          cnt_d   = cnt_q + 1'b1;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
          if (cnt_q == len_q) state_d = ST_CHK;
`else
          if (cnt_q == len_q) state_d = ST_DONE;
`endif
        end
      end
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        // The last write issued on an earlier cycle, so release may happen on this edge.
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (start) begin
          state_d = ST_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          err_d   = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        if (start) begin
          state_d = ST_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end else if (!done_q) begin
          // Entered straight from DATA: release one cycle later, after the final write cycle.
          done_d = 1'b1;
          hold_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = ready;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
  assign load_err  = err_q;
`else
  assign load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Scoreboard bench for cpu_prog_loader: a frame model queues the expected writes, and a monitor checks every mem_we cycle against that queue.
module tb_cpu_prog_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready, mem_we, cpu_hold, load_done, load_err;
  logic [3:0] mem_addr, mem_wdata;

  cpu_prog_loader #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  bit mon_en = 1'b0;
  logic [3:0] exp_a[$];
  logic [3:0] exp_d[$];
  logic [3:0] ea, ed;
  logic [3:0] fd[16];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && reset && mem_we) begin
      chk("hold_during_write", cpu_hold, 1);
      if (exp_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%0d expected=none", mem_addr, mem_wdata);
      end else begin
        ea = exp_a.pop_front();
        ed = exp_d.pop_front();
        chk("wr_addr", mem_addr, ea);
        chk("wr_data", mem_wdata, ed);
      end
      last_we_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] v, input bit gaps);
    int t;
    if (gaps) begin
      int n;
      n = $urandom_range(0, 3);
      repeat (n) begin
        in_valid = 1'b0;
        start = 1'($urandom_range(0, 1));
        in_data = 4'($urandom);
        tick();
      end
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data = v;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=0 expected=1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Model: word k lands at (base+k) mod 16; checksum is the mod-16 sum of the data words.
  task automatic run_frame(input int len, input int base, input bit good_chk, input bit gaps);
    int sum;
    int c;
    bit ok;
    sum = 0;
    for (int k = 0; k <= len; k++) begin
      exp_a.push_back(4'((base + k) % 16));
      exp_d.push_back(fd[k]);
      sum += fd[k];
    end
    pulse_start();
    chk("ready_in_len", in_ready, 1);
    chk("hold_in_len", cpu_hold, 1);
    chk("done_cleared", load_done, 0);
    chk("err_cleared", load_err, 0);
    send(4'(len), gaps);
    send(4'(base), gaps);
    for (int k = 0; k <= len; k++) send(fd[k], gaps);
`ifdef CPU_PROG_LOADER_CHECKSUM_EN
    ok = good_chk;
    if (good_chk) send(4'(sum % 16), gaps);
    else send(4'((sum + 1 + $urandom_range(0, 14)) % 16), gaps);
`else
    ok = 1'b1;
`endif
    c = 0;
    while (!(load_done || load_err) && c < 40) begin
      tick();
      c++;
    end
    chk("load_done", load_done, ok);
    chk("load_err", load_err, !ok);
    chk("cpu_hold", cpu_hold, !ok);
`ifndef CPU_PROG_LOADER_CHECKSUM_EN
    chk("done_latency", cyc, last_we_cyc + 1);
`endif
    tick();
    tick();
    chk("writes_outstanding", exp_a.size(), 0);
  endtask

  initial begin
    bit good;
    repeat (3) tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    reset = 1'b1;
    mon_en = 1'b1;
    tick();

    // start and in_valid together in IDLE: the nibble must not be taken as LEN
    start = 1'b1; in_valid = 1'b1; in_data = 4'd9;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("start_wins_ready", in_ready, 1);

    fd[0] = 4'd1; fd[1] = 4'd3; fd[2] = 4'd2;
    run_frame(2, 0, 1'b1, 1'b0);

    fd[0] = 4'hA; fd[1] = 4'hB; fd[2] = 4'hC; fd[3] = 4'hD;
    run_frame(3, 14, 1'b1, 1'b0);

`ifdef CPU_PROG_LOADER_CHECKSUM_EN
    fd[0] = 4'd1; fd[1] = 4'd3; fd[2] = 4'd2;
    run_frame(2, 0, 1'b0, 1'b0);
`endif

    fd[0] = 4'hA; fd[1] = 4'hB; fd[2] = 4'hC; fd[3] = 4'hD;
    run_frame(3, 14, 1'b1, 1'b1);

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 16; k++) fd[k] = 4'($urandom);
      good = ($urandom_range(0, 3) != 0);
      run_frame($urandom_range(0, 15), $urandom_range(0, 15), good, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of DATA
    mon_en = 1'b0;
    pulse_start();
    send(4'd7, 1'b0);
    send(4'd5, 1'b0);
    send(4'd3, 1'b0);
    send(4'd6, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_wdata", mem_wdata, 0);
    chk("midrst_hold", cpu_hold, 1);
    chk("midrst_done", load_done, 0);
    chk("midrst_err", load_err, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("postrst_ready", in_ready, 0);
    exp_a.delete();
    exp_d.delete();
    mon_en = 1'b1;

    for (int k = 0; k < 16; k++) fd[k] = 4'($urandom);
    run_frame(15, 3, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
